// File: rtl/wrr_input_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin input arbiter.
package wrr_input_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        WR_PKT = 1'b1
    } state_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A non-zero ctrl only closes a packet once a data word has been seen.
    function automatic logic is_eop(
        input logic ctrl_nonzero,
        input logic prev_ctrl_zero
    );
        return ctrl_nonzero && prev_ctrl_zero;
    endfunction

endpackage

// File: rtl/small_fifo.sv
// Small first-word-fall-through FIFO; head word visible while !empty.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2,
    parameter int NEARLY_FULL    = (2 ** MAX_DEPTH_BITS) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 2 ** MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS:0]   depth;
    logic                      full;
    logic                      wr_ok;
    logic                      rd_ok;

    assign full        = (depth == (MAX_DEPTH_BITS + 1)'(DEPTH));
    assign empty       = (depth == '0);
    assign nearly_full = (depth >= (MAX_DEPTH_BITS + 1)'(NEARLY_FULL));
    assign wr_ok       = wr_en && !full;
    assign rd_ok       = rd_en && !empty;
    assign dout        = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            depth  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   depth <= depth + 1'b1;
                2'b01:   depth <= depth - 1'b1;
                default: depth <= depth;
            endcase
        end
    end

endmodule

// File: rtl/wrr_next_queue.sv
// Rotating priority search: first eligible queue after cur_queue, itself last.
module wrr_next_queue #(
    parameter int NUM_QUEUES  = 4,
    parameter int QUEUE_WIDTH = 2
) (
    input  logic [NUM_QUEUES-1:0]  eligible,
    input  logic [QUEUE_WIDTH-1:0] cur_queue,
    output logic                   found,
    output logic [QUEUE_WIDTH-1:0] next_queue
);

    int                   idx;
    logic [QUEUE_WIDTH-1:0] qi;

    always_comb begin
        found      = 1'b0;
        next_queue = cur_queue;
        idx        = 0;
        qi         = '0;
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = int'(cur_queue) + k;
            if (idx >= NUM_QUEUES) begin
                idx = idx - NUM_QUEUES;
            end
            qi = QUEUE_WIDTH'(idx);
            if (!found && eligible[qi]) begin
                found      = 1'b1;
                next_queue = qi;
            end
        end
    end

endmodule

// File: rtl/wrr_input_arbiter.sv
// Packet-level weighted round-robin merge of rx queues onto one datapath bus.
module wrr_input_arbiter
    import wrr_input_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int CTRL_WIDTH   = DATA_WIDTH / 8,
    parameter int NUM_QUEUES   = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int QUEUE_WIDTH  = log2(NUM_QUEUES)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]   in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0]   in_ctrl,
    input  logic [NUM_QUEUES-1:0]              in_wr,
    output logic [NUM_QUEUES-1:0]              in_rdy,
    input  logic [NUM_QUEUES*WEIGHT_WIDTH-1:0] weights,
    output logic [DATA_WIDTH-1:0]              out_data,
    output logic [CTRL_WIDTH-1:0]              out_ctrl,
    output logic                               out_wr,
    input  logic                               out_rdy,
    output logic [QUEUE_WIDTH-1:0]             grant_queue,
    output logic                               pkt_done
);

    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [QUEUE_WIDTH-1:0] LAST_Q = QUEUE_WIDTH'(NUM_QUEUES - 1);

    logic [WORD_W-1:0]       head_word [NUM_QUEUES];
    logic [DATA_WIDTH-1:0]   head_data [NUM_QUEUES];
    logic [CTRL_WIDTH-1:0]   head_ctrl [NUM_QUEUES];
    logic [WEIGHT_WIDTH-1:0] weight    [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   empty;
    logic [NUM_QUEUES-1:0]   nearly_full;
    logic [NUM_QUEUES-1:0]   eligible;
    logic [NUM_QUEUES-1:0]   rd_en;

    state_t                  state;
    logic [QUEUE_WIDTH-1:0]  cur_queue;
    logic [WEIGHT_WIDTH-1:0] credit;
    logic                    prev_ctrl_zero;

    logic                    nq_found;
    logic [QUEUE_WIDTH-1:0]  nq_next;
    logic                    keep;
    logic [QUEUE_WIDTH-1:0]  grant_q;
    logic                    grant;
    logic                    wr_pkt_rd;
    logic                    mid_rd;
    logic                    eop;
    logic [QUEUE_WIDTH-1:0]  sel_q;
    logic [DATA_WIDTH-1:0]   sel_data;
    logic [CTRL_WIDTH-1:0]   sel_ctrl;
    logic                    ctrl_zero;

    for (genvar gi = 0; gi < NUM_QUEUES; gi++) begin : g_q
        small_fifo #(
            .WIDTH          (WORD_W),
            .MAX_DEPTH_BITS (2)
        ) u_fifo (
            .clk         (clk),
            .reset       (reset),
            .din         ({in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH],
                           in_data[gi*DATA_WIDTH +: DATA_WIDTH]}),
            .wr_en       (in_wr[gi]),
            .rd_en       (rd_en[gi]),
            .dout        (head_word[gi]),
            .nearly_full (nearly_full[gi]),
            .empty       (empty[gi])
        );

        assign head_data[gi] = head_word[gi][DATA_WIDTH-1:0];
        assign head_ctrl[gi] = head_word[gi][WORD_W-1:DATA_WIDTH];
        assign weight[gi]    = weights[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        assign eligible[gi]  = !empty[gi] && (weight[gi] != '0);
        assign in_rdy[gi]    = !nearly_full[gi];
    end

    wrr_next_queue #(
        .NUM_QUEUES  (NUM_QUEUES),
        .QUEUE_WIDTH (QUEUE_WIDTH)
    ) u_next (
        .eligible   (eligible),
        .cur_queue  (cur_queue),
        .found      (nq_found),
        .next_queue (nq_next)
    );

    // Remaining credit keeps the current queue; otherwise rotate and reload.
    assign keep      = (credit != '0) && eligible[cur_queue];
    assign grant_q   = keep ? cur_queue : nq_next;
    assign grant     = (state == IDLE) && out_rdy && (keep || nq_found);
    assign wr_pkt_rd = (state == WR_PKT) && out_rdy && !empty[cur_queue];
    assign sel_q     = (state == IDLE) ? grant_q : cur_queue;
    assign sel_data  = head_data[sel_q];
    assign sel_ctrl  = head_ctrl[sel_q];
    assign ctrl_zero = (sel_ctrl == '0);
    assign eop       = wr_pkt_rd && is_eop(!ctrl_zero, prev_ctrl_zero);
    assign mid_rd    = wr_pkt_rd && !eop;

    assign grant_queue = cur_queue;

    always_comb begin
        rd_en = '0;
        if (grant || wr_pkt_rd) begin
            rd_en[sel_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cur_queue      <= LAST_Q;
            credit         <= '0;
            prev_ctrl_zero <= 1'b0;
            out_wr         <= 1'b0;
            out_data       <= '0;
            out_ctrl       <= '0;
            pkt_done       <= 1'b0;
        end else begin
            out_wr   <= grant || wr_pkt_rd;
            pkt_done <= eop;
            if (grant || wr_pkt_rd) begin
                out_data <= sel_data;
                out_ctrl <= sel_ctrl;
            end
            unique case (1'b1)
                grant: begin
                    state          <= WR_PKT;
                    prev_ctrl_zero <= ctrl_zero;
                    if (!keep) begin
                        cur_queue <= nq_next;
                        credit    <= weight[nq_next];
                    end
                end
                eop: begin
                    state  <= IDLE;
                    credit <= credit - 1'b1;
                end
                mid_rd: begin
                    prev_ctrl_zero <= ctrl_zero;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_input_arbiter.sv
// Self-checking bench: packet order tables plus stall/reset corner sequences.
module tb_wrr_input_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int WW = 4;
    localparam int QW = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NQ*DW-1:0]  in_data = '0;
    logic [NQ*CW-1:0]  in_ctrl = '0;
    logic [NQ-1:0]     in_wr = '0;
    logic [NQ-1:0]     in_rdy;
    logic [NQ*WW-1:0]  weights = '0;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ctrl;
    logic              out_wr;
    logic              out_rdy = 1'b0;
    logic [QW-1:0]     grant_queue;
    logic              pkt_done;

    wrr_input_arbiter #(
        .DATA_WIDTH   (DW),
        .CTRL_WIDTH   (CW),
        .NUM_QUEUES   (NQ),
        .WEIGHT_WIDTH (WW),
        .QUEUE_WIDTH  (QW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_ctrl     (in_ctrl),
        .in_wr       (in_wr),
        .in_rdy      (in_rdy),
        .weights     (weights),
        .out_data    (out_data),
        .out_ctrl    (out_ctrl),
        .out_wr      (out_wr),
        .out_rdy     (out_rdy),
        .grant_queue (grant_queue),
        .pkt_done    (pkt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [QW-1:0] q;
        logic          eop;
    } word_t;

    typedef struct {
        logic [NQ*WW-1:0] w;
        int               npkt  [NQ];
        int               order [8];
        int               n;
    } vec_t;

    word_t src [NQ][$];
    word_t sb [$];
    word_t drv_w;
    word_t mon_w;
    vec_t  vecs [3];

    int   errors = 0;
    int   checks = 0;
    int   wr_cnt = 0;
    int   done_cnt = 0;
    logic rdy_q = 1'b0;

    function automatic word_t mk(int v, int q, int p, int w, int n, int nh);
        word_t r;
        r.data = {8'(v), 8'(q), 16'(p), 16'(w), 16'hBEEF};
        if (w < nh) r.ctrl = 8'(8'hF0 + w);
        else if (w == n - 1) r.ctrl = 8'h01;
        else r.ctrl = 8'h00;
        r.q   = QW'(q);
        r.eop = (w == n - 1);
        return r;
    endfunction

    task automatic add_pkt(int v, int q, int p, int n, int nh);
        for (int w = 0; w < n; w++) src[q].push_back(mk(v, q, p, w, n, nh));
    endtask

    task automatic expect_pkt(int v, int q, int p, int n, int nh);
        for (int w = 0; w < n; w++) sb.push_back(mk(v, q, p, w, n, nh));
    endtask

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(posedge clk) rdy_q = out_rdy;

    // Upstream queue models: write only while the FIFO reports room.
    always @(negedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (reset && in_rdy[q] && src[q].size() > 0) begin
                drv_w = src[q].pop_front();
                in_data[q*DW +: DW] = drv_w.data;
                in_ctrl[q*CW +: CW] = drv_w.ctrl;
                in_wr[q] = 1'b1;
            end else begin
                in_wr[q] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            if (out_wr) begin
                wr_cnt++;
                if (pkt_done) done_cnt++;
                checks++;
                if (!rdy_q) begin
                    errors++;
                    $display("FAIL wr_without_rdy data=%h", out_data);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr q=%0d data=%h",
                             grant_queue, out_data);
                end else begin
                    mon_w = sb.pop_front();
                    if ({out_data, out_ctrl, grant_queue, pkt_done} !==
                        {mon_w.data, mon_w.ctrl, mon_w.q, mon_w.eop}) begin
                        errors++;
                        $display("FAIL word got q=%0d d=%h c=%h done=%b want q=%0d d=%h c=%h done=%b",
                                 grant_queue, out_data, out_ctrl, pkt_done,
                                 mon_w.q, mon_w.data, mon_w.ctrl, mon_w.eop);
                    end
                end
            end else if (pkt_done) begin
                checks++;
                errors++;
                $display("FAIL stray_pkt_done got=1 want=0");
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        out_rdy = 1'b0;
        for (int q = 0; q < NQ; q++) src[q].delete();
        sb.delete();
        #1;
        chk("rst_out_wr", 64'(out_wr), 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        chk("rst_grant_queue", 64'(grant_queue), 64'(NQ - 1));
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_in_rdy", 64'(in_rdy), 64'hF);
        reset = 1'b1;
    endtask

    task automatic wait_drain(string name, int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    int d0;
    int w0;
    int nxt [NQ];
    bit hit;
    word_t third;

    initial begin
        vecs[0].w     = {4'd1, 4'd1, 4'd1, 4'd1};
        vecs[0].npkt  = '{3, 0, 3, 0};
        vecs[0].order = '{0, 2, 0, 2, 0, 2, 0, 0};
        vecs[0].n     = 6;
        vecs[1].w     = {4'd0, 4'd0, 4'd1, 4'd3};
        vecs[1].npkt  = '{4, 4, 0, 0};
        vecs[1].order = '{0, 0, 0, 1, 0, 1, 1, 1};
        vecs[1].n     = 8;
        vecs[2].w     = {4'd2, 4'd0, 4'd0, 4'd1};
        vecs[2].npkt  = '{2, 0, 0, 3};
        vecs[2].order = '{0, 3, 3, 0, 3, 0, 0, 0};
        vecs[2].n     = 5;

        for (int v = 0; v < 3; v++) begin
            do_reset();
            weights = vecs[v].w;
            for (int q = 0; q < NQ; q++) begin
                nxt[q] = 0;
                for (int p = 0; p < vecs[v].npkt[q]; p++) add_pkt(v, q, p, 4, 1);
            end
            for (int k = 0; k < vecs[v].n; k++) begin
                expect_pkt(v, vecs[v].order[k], nxt[vecs[v].order[k]], 4, 1);
                nxt[vecs[v].order[k]]++;
            end
            d0 = done_cnt;
            w0 = wr_cnt;
            repeat (6) @(negedge clk);
            out_rdy = 1'b1;
            wait_drain("vec_drain", 400);
            chk("vec_pkt_done", 64'(done_cnt - d0), 64'(vecs[v].n));
            chk("vec_wr_count", 64'(wr_cnt - w0), 64'(4 * vecs[v].n));
        end

        // Zero weight: queue 1 is never served and backs up.
        do_reset();
        weights = {4'd0, 4'd0, 4'd0, 4'd2};
        add_pkt(20, 1, 0, 4, 1);
        add_pkt(20, 1, 1, 4, 1);
        w0 = wr_cnt;
        out_rdy = 1'b1;
        repeat (40) @(negedge clk);
        chk("w0_no_wr", 64'(wr_cnt - w0), 64'd0);
        chk("w0_in_rdy1", 64'(in_rdy[1]), 64'd0);
        chk("w0_in_rdy0", 64'(in_rdy[0]), 64'd1);
        chk("w0_src_left", 64'(src[1].size()), 64'd5);

        // Backpressure toggling through a 6-word packet.
        do_reset();
        weights = {4'd0, 4'd0, 4'd0, 4'd1};
        add_pkt(30, 0, 0, 6, 2);
        expect_pkt(30, 0, 0, 6, 2);
        d0 = done_cnt;
        w0 = wr_cnt;
        repeat (6) @(negedge clk);
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(negedge clk);
            out_rdy = ~out_rdy;
        end
        out_rdy = 1'b0;
        repeat (6) @(negedge clk);
        chk("tog_drain", 64'(sb.size()), 64'd0);
        chk("tog_pkt_done", 64'(done_cnt - d0), 64'd1);
        chk("tog_wr_count", 64'(wr_cnt - w0), 64'd6);

        // Queue 0 runs dry mid-packet; no switch to the full queue 1.
        do_reset();
        weights = {4'd0, 4'd0, 4'd1, 4'd1};
        src[0].push_back(mk(40, 0, 0, 0, 4, 1));
        src[0].push_back(mk(40, 0, 0, 1, 4, 1));
        add_pkt(40, 1, 0, 4, 1);
        expect_pkt(40, 0, 0, 4, 1);
        expect_pkt(40, 1, 0, 4, 1);
        d0 = done_cnt;
        w0 = wr_cnt;
        repeat (6) @(negedge clk);
        out_rdy = 1'b1;
        repeat (15) @(negedge clk);
        chk("dry_wr_count", 64'(wr_cnt - w0), 64'd2);
        chk("dry_grant", 64'(grant_queue), 64'd0);
        chk("dry_in_rdy1", 64'(in_rdy[1]), 64'd0);
        src[0].push_back(mk(40, 0, 0, 2, 4, 1));
        src[0].push_back(mk(40, 0, 0, 3, 4, 1));
        wait_drain("dry_drain", 100);
        chk("dry_pkt_done", 64'(done_cnt - d0), 64'd2);

        // Reset during the third word of a packet.
        do_reset();
        weights = {4'd1, 4'd1, 4'd1, 4'd1};
        add_pkt(50, 2, 0, 4, 1);
        expect_pkt(50, 2, 0, 4, 1);
        third = mk(50, 2, 0, 2, 4, 1);
        repeat (6) @(negedge clk);
        out_rdy = 1'b1;
        hit = 1'b0;
        for (int n = 0; n < 50 && !hit; n++) begin
            @(posedge clk);
            #1;
            if (out_wr && out_data == third.data) hit = 1'b1;
        end
        chk("rst_mid_reached", 64'(hit), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_out_wr", 64'(out_wr), 64'd0);
        chk("rst_mid_grant", 64'(grant_queue), 64'(NQ - 1));
        chk("rst_mid_credit", 64'(dut.credit), 64'd0);
        chk("rst_mid_pkt_done", 64'(pkt_done), 64'd0);
        @(negedge clk);
        out_rdy = 1'b0;
        for (int q = 0; q < NQ; q++) src[q].delete();
        sb.delete();
        add_pkt(51, 3, 0, 4, 1);
        add_pkt(51, 1, 0, 4, 1);
        expect_pkt(51, 1, 0, 4, 1);
        expect_pkt(51, 3, 0, 4, 1);
        d0 = done_cnt;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        out_rdy = 1'b1;
        wait_drain("post_rst_drain", 100);
        chk("post_rst_pkt_done", 64'(done_cnt - d0), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
